// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: buffers HPS writes to VRAM in a FIFO and drains them into the
// PPU VRAM write port only while vblank is high, so CPU writes never tear the visible frame.
// cpu_vram_wr_irq reports that every buffered write has reached VRAM in the current vblank.
// Optional feature: define VRAM_WR_COALESCE_EN to merge a write into the most recently
// pushed entry when the addresses match (per-byte merge, byte enables OR'd).
module vram_write_scheduler #(
    parameter int unsigned ADDR_W     = 13,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          clock_clk,
    input  logic                          reset_reset,
    input  logic [ADDR_W-1:0]             hps_wraddr,
    input  logic                          hps_wren,
    input  logic [DATA_W-1:0]             hps_wrdata,
    input  logic [DATA_W/8-1:0]           hps_byteena,
    output logic                          hps_waitrequest,
    input  logic                          vblank,
    output logic [ADDR_W-1:0]             vram_wraddr,
    output logic                          vram_wren,
    output logic [DATA_W-1:0]             vram_wrdata,
    output logic [DATA_W/8-1:0]           vram_byteena,
    output logic                          cpu_vram_wr_irq,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned BeW  = DATA_W / 8;
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);
    localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

    typedef enum logic [1:0] {StIdle, StDrain, StDone} state_e;

    state_e            state_q;
    logic              vblank_q;
    logic              irq_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [PtrW-1:0]   rd_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [CntW-1:0]   count_d;

    logic [ADDR_W-1:0] addr_mem [FIFO_DEPTH];
    logic [DATA_W-1:0] data_mem [FIFO_DEPTH];
    logic [BeW-1:0]    be_mem   [FIFO_DEPTH];

    logic              vram_wren_q;
    logic [ADDR_W-1:0] vram_addr_q;
    logic [DATA_W-1:0] vram_data_q;
    logic [BeW-1:0]    vram_be_q;

    logic              full;
    logic              push;
    logic              pop;
    logic              vblank_rise;

    // Pop whenever draining with data available; rising vblank detected against the last sample.
    always_comb begin
        full        = (count_q == FullCnt);
        pop         = (state_q == StDrain) && (count_q != '0);
        vblank_rise = vblank && !vblank_q;
    end

`ifdef VRAM_WR_COALESCE_EN
    logic [PtrW-1:0]   tail_ptr;
    logic              merge_hit;
    logic              merge;
    logic [DATA_W-1:0] merged_data;

    // Match against the newest entry; never merge into an entry leaving the FIFO this cycle.
    always_comb begin
        tail_ptr    = wr_ptr_q - PtrOne;
        merge_hit   = (count_q != '0) && (addr_mem[tail_ptr] == hps_wraddr) &&
                      !(pop && (rd_ptr_q == tail_ptr));
        merged_data = data_mem[tail_ptr];
        for (int i = 0; i < BeW; i++) begin
            if (hps_byteena[i]) begin
                merged_data[i*8 +: 8] = hps_wrdata[i*8 +: 8];
            end
        end
        // A merge needs no free slot, so it is accepted even when full.
        hps_waitrequest = full && !merge_hit;
        merge           = hps_wren && !hps_waitrequest && merge_hit;
        push            = hps_wren && !hps_waitrequest && !merge_hit;
    end
`else
    // Every accepted write allocates a new entry.
    always_comb begin
        hps_waitrequest = full;
        push            = hps_wren && !full;
    end
`endif

    // Occupancy tracked separately from the wrapping pointers.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // FIFO storage; contents need no reset because the pointers and count define validity.
    always_ff @(posedge clock_clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= hps_wraddr;
            data_mem[wr_ptr_q] <= hps_wrdata;
            be_mem[wr_ptr_q]   <= hps_byteena;
        end
`ifdef VRAM_WR_COALESCE_EN
        else if (merge) begin
            data_mem[tail_ptr] <= merged_data;
            be_mem[tail_ptr]   <= be_mem[tail_ptr] | hps_byteena;
        end
`endif
    end

    // Control FSM, pointers, count and registered VRAM/IRQ outputs.
    always_ff @(posedge clock_clk) begin
        if (reset_reset) begin
            state_q     <= StIdle;
            vblank_q    <= 1'b1;  // vblank already high out of reset is not a rising edge
            irq_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            vram_wren_q <= 1'b0;
            vram_addr_q <= '0;
            vram_data_q <= '0;
            vram_be_q   <= '0;
        end else begin
            vblank_q    <= vblank;
            irq_q       <= (state_q == StDone);
            count_q     <= count_d;
            vram_wren_q <= pop;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + PtrOne;
                vram_addr_q <= addr_mem[rd_ptr_q];
                vram_data_q <= data_mem[rd_ptr_q];
                vram_be_q   <= be_mem[rd_ptr_q];
            end
            unique case (state_q)
                StIdle: begin
                    if (vblank_rise) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (!vblank) begin
                        state_q <= StIdle;
                    end else if ((count_q == '0) && !push) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (!vblank) begin
                        state_q <= StIdle;
                    end else if (push) begin
                        state_q <= StDrain;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign vram_wren       = vram_wren_q;
    assign vram_wraddr     = vram_addr_q;
    assign vram_wrdata     = vram_data_q;
    assign vram_byteena    = vram_be_q;
    assign cpu_vram_wr_irq = irq_q;
    assign fifo_level      = count_q;

endmodule

// File: tb/tb_vram_write_scheduler.sv
// Directed bench for vram_write_scheduler with an in-order scoreboard on the VRAM port.
module tb_vram_write_scheduler;

    logic        clock_clk = 1'b0;
    logic        reset_reset;
    logic [12:0] hps_wraddr;
    logic        hps_wren;
    logic [63:0] hps_wrdata;
    logic [7:0]  hps_byteena;
    logic        hps_waitrequest;
    logic        vblank;
    logic [12:0] vram_wraddr;
    logic        vram_wren;
    logic [63:0] vram_wrdata;
    logic [7:0]  vram_byteena;
    logic        cpu_vram_wr_irq;
    logic [4:0]  fifo_level;

    typedef struct {
        logic [12:0] a;
        logic [63:0] d;
        logic [7:0]  be;
    } ent_t;

    ent_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   n_vram   = 0;
    int   base;

    always #5 clock_clk = ~clock_clk;

    vram_write_scheduler dut (
        .clock_clk       (clock_clk),
        .reset_reset     (reset_reset),
        .hps_wraddr      (hps_wraddr),
        .hps_wren        (hps_wren),
        .hps_wrdata      (hps_wrdata),
        .hps_byteena     (hps_byteena),
        .hps_waitrequest (hps_waitrequest),
        .vblank          (vblank),
        .vram_wraddr     (vram_wraddr),
        .vram_wren       (vram_wren),
        .vram_wrdata     (vram_wrdata),
        .vram_byteena    (vram_byteena),
        .cpu_vram_wr_irq (cpu_vram_wr_irq),
        .fifo_level      (fifo_level)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock_clk);
        #1;
    endtask

    // Issue one write, waiting (bounded) for acceptance; mrg folds it into the model tail.
    task automatic wr(input logic [12:0] a, input logic [63:0] d, input logic [7:0] be,
                      input bit mrg);
        int   n;
        ent_t t;
        hps_wraddr  = a;
        hps_wrdata  = d;
        hps_byteena = be;
        hps_wren    = 1'b1;
        #1;
        n = 0;
        while (hps_waitrequest && n < 64) begin
            tick();
            n++;
        end
        check("wr_accept", hps_waitrequest, 1'b0);
        if (!hps_waitrequest) begin
            tick();
            if (mrg && exp_q.size() > 0) begin
                t = exp_q[exp_q.size()-1];
                for (int i = 0; i < 8; i++) begin
                    if (be[i]) t.d[i*8 +: 8] = d[i*8 +: 8];
                end
                t.be = t.be | be;
                exp_q[exp_q.size()-1] = t;
            end else begin
                t.a  = a;
                t.d  = d;
                t.be = be;
                exp_q.push_back(t);
            end
        end
        hps_wren = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while ((fifo_level != 0 || vram_wren) && n < 100) begin
            tick();
            n++;
        end
        check(tag, fifo_level, 0);
        tick();
        tick();
    endtask

    function automatic logic [63:0] dat(input logic [12:0] a);
        return 64'hA5A5_0000_0000_0000 | {51'd0, a};
    endfunction

    // Scoreboard: every VRAM write must match the next accepted write in order.
    always @(negedge clock_clk) begin
        if (!reset_reset && vram_wren) begin
            ent_t e;
            n_vram++;
            if (exp_q.size() == 0) begin
                check("vram_unexpected", vram_wren, 1'b0);
            end else begin
                e = exp_q.pop_front();
                check("vram_addr", vram_wraddr, e.a);
                check("vram_data", vram_wrdata, e.d);
                check("vram_be", vram_byteena, e.be);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset_reset = 1'b1;
        hps_wraddr  = '0;
        hps_wren    = 1'b0;
        hps_wrdata  = '0;
        hps_byteena = '0;
        vblank      = 1'b0;
        tick();
        tick();
        reset_reset = 1'b0;
        #1;
        check("rst_wren", vram_wren, 0);
        check("rst_level", fifo_level, 0);
        check("rst_waitreq", hps_waitrequest, 0);
        check("rst_irq", cpu_vram_wr_irq, 0);
        check("rst_addr", vram_wraddr, 0);
        tick();

        // Three writes held while vblank is low.
        base = n_vram;
        wr(13'h010, dat(13'h010), 8'hFF, 0);
        wr(13'h011, dat(13'h011), 8'h0F, 0);
        wr(13'h012, dat(13'h012), 8'hF0, 0);
        tick();
        tick();
        check("t1_wren", vram_wren, 0);
        check("t1_level", fifo_level, 3);
        check("t1_irq", cpu_vram_wr_irq, 0);
        check("t1_nvram", n_vram - base, 0);

        // Rising vblank drains three consecutive words, then IRQ.
        vblank = 1'b1;
        tick();
        check("t2_wren_r0", vram_wren, 0);
        tick();
        check("t2_wren_r1", vram_wren, 1);
        check("t2_addr_r1", vram_wraddr, 13'h010);
        tick();
        check("t2_wren_r2", vram_wren, 1);
        tick();
        check("t2_wren_r3", vram_wren, 1);
        check("t2_level", fifo_level, 0);
        tick();
        check("t2_wren_r4", vram_wren, 0);
        check("t2_irq_r4", cpu_vram_wr_irq, 0);
        tick();
        check("t2_irq_r5", cpu_vram_wr_irq, 1);
        check("t2_nvram", n_vram - base, 3);
        vblank = 1'b0;
        tick();
        tick();
        check("t2_irq_fall", cpu_vram_wr_irq, 0);

        // Fill to full, hold a 17th write across the vblank rise.
        base = n_vram;
        for (int i = 0; i < 16; i++) begin
            wr(13'h100 + 13'(i), dat(13'h100 + 13'(i)), 8'hFF, 0);
        end
        #1;
        check("t3_full_waitreq", hps_waitrequest, 1);
        check("t3_full_level", fifo_level, 16);
        hps_wraddr  = 13'h0FF;
        hps_wrdata  = dat(13'h0FF);
        hps_byteena = 8'h3C;
        hps_wren    = 1'b1;
        vblank      = 1'b1;
        tick();
        check("t3_waitreq_r0", hps_waitrequest, 1);
        tick();
        check("t3_waitreq_r1", hps_waitrequest, 0);
        tick();
        begin
            ent_t t;
            t.a  = 13'h0FF;
            t.d  = dat(13'h0FF);
            t.be = 8'h3C;
            exp_q.push_back(t);
        end
        hps_wren = 1'b0;
        wait_empty("t3_empty");
        check("t3_nvram", n_vram - base, 17);
        check("t3_irq", cpu_vram_wr_irq, 1);

        // vblank falls after two of five entries drained.
        vblank = 1'b0;
        tick();
        tick();
        base = n_vram;
        for (int i = 0; i < 5; i++) begin
            wr(13'h030 + 13'(i), dat(13'h030 + 13'(i)), 8'hFF, 0);
        end
        vblank = 1'b1;
        tick();
        tick();
        vblank = 1'b0;
        tick();
        tick();
        tick();
        check("t4_wren_stop", vram_wren, 0);
        check("t4_level", fifo_level, 3);
        check("t4_nvram_part", n_vram - base, 2);
        vblank = 1'b1;
        wait_empty("t4_empty");
        check("t4_nvram_all", n_vram - base, 5);

        // Empty FIFO at vblank rise, then a late write during DONE.
        vblank = 1'b0;
        tick();
        tick();
        check("t5_irq_idle", cpu_vram_wr_irq, 0);
        vblank = 1'b1;
        tick();
        tick();
        check("t5_irq_r1", cpu_vram_wr_irq, 0);
        tick();
        check("t5_irq_r2", cpu_vram_wr_irq, 1);
        base = n_vram;
        wr(13'h040, dat(13'h040), 8'h81, 0);
        tick();
        check("t5_irq_drop", cpu_vram_wr_irq, 0);
        check("t5_wren", vram_wren, 1);
        tick();
        tick();
        check("t5_irq_again", cpu_vram_wr_irq, 1);
        check("t5_nvram", n_vram - base, 1);

        // Reset mid-drain discards contents; vblank high out of reset does not drain.
        vblank = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            wr(13'h050 + 13'(i), dat(13'h050 + 13'(i)), 8'hFF, 0);
        end
        vblank = 1'b1;
        tick();
        tick();
        reset_reset = 1'b1;
        tick();
        check("t6_rst_wren", vram_wren, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_irq", cpu_vram_wr_irq, 0);
        exp_q.delete();
        reset_reset = 1'b0;
        base = n_vram;
        tick();
        tick();
        tick();
        check("t6_post_wren", vram_wren, 0);
        wr(13'h060, dat(13'h060), 8'h11, 0);
        tick();
        tick();
        tick();
        check("t6_hold_level", fifo_level, 1);
        check("t6_hold_nvram", n_vram - base, 0);
        vblank = 1'b0;
        tick();
        vblank = 1'b1;
        wait_empty("t6_empty");
        check("t6_nvram", n_vram - base, 1);

`ifdef VRAM_WR_COALESCE_EN
        // Two partial writes to one address merge into a single entry.
        vblank = 1'b0;
        tick();
        tick();
        base = n_vram;
        wr(13'h020, 64'h0000_0000_0000_00AA, 8'h01, 0);
        wr(13'h020, 64'h0000_0000_0000_BB00, 8'h02, 1);
        #1;
        check("tc_level", fifo_level, 1);
        vblank = 1'b1;
        tick();
        tick();
        check("tc_data", vram_wrdata[15:0], 16'hBBAA);
        check("tc_be", vram_byteena, 8'h03);
        wait_empty("tc_empty");
        check("tc_nvram", n_vram - base, 1);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
